// File: rtl/iec_sd_responder_if.sv
// Drive sector-buffer and backing-memory bus of iec_sd_responder.
// master = the responder; slave = the emulated drives plus the image memory.
interface iec_sd_responder_if #(
   parameter int NDR    = 2,
   parameter int MEM_AW = 24
);
   logic [NDR-1:0][31:0] sd_lba;
   logic [NDR-1:0][5:0]  sd_blk_cnt;
   logic [NDR-1:0]       sd_rd;
   logic [NDR-1:0]       sd_wr;
   logic [NDR-1:0]       sd_ack;
   logic [12:0]          sd_buff_addr;
   logic [7:0]           sd_buff_dout;
   logic                 sd_buff_wr;
   logic [NDR-1:0][7:0]  sd_buff_din;
   logic [MEM_AW-1:0]    mem_addr;
   logic                 mem_rd;
   logic                 mem_wr;
   logic [7:0]           mem_din;
   logic [7:0]           mem_dout;
   logic                 mem_ready;
   logic                 busy;

   modport master (
      input  sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din, mem_dout, mem_ready,
      output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr, mem_rd, mem_wr,
             mem_din, busy
   );
   modport slave (
      output sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din, mem_dout, mem_ready,
      input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr, mem_rd, mem_wr,
             mem_din, busy
   );
endinterface

// File: rtl/iec_sd_responder.sv
// Round-robin drive block-request responder copying 512-byte blocks between image memory and
// drive sector buffers. Define SD_WRPROT_EN to add per-drive write protect (wp / wp_err).
module iec_sd_responder #(
   parameter int  DRIVES = 2,
   parameter int  MEM_AW = 24,
   localparam int NDR    = (DRIVES < 1) ? 1 : ((DRIVES > 4) ? 4 : DRIVES),
   localparam int DW     = (NDR > 2) ? 2 : 1
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   iec_sd_responder_if.master bus
`ifdef SD_WRPROT_EN
  ,input  logic [NDR-1:0]     wp,
   output logic               wp_err
`endif
);
   typedef enum logic [2:0] {
      IDLE, GRANT, RD_REQ, RD_PUT, WR_ADDR, WR_CAP, WR_MEM, DONE
   } state_t;

   state_t            state_q, state_d;
   logic [DW-1:0]     rr_q, rr_d, drv_q, drv_d;
   logic              dir_rd_q, dir_rd_d;
   logic [31:0]       lba_q, lba_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [12:0]       off_q, off_d;
   logic [NDR-1:0]    ack_q, ack_d;
   logic [12:0]       baddr_q, baddr_d;
   logic [7:0]        bdout_q, bdout_d;
   logic              bwr_q, bwr_d;
   logic [MEM_AW-1:0] maddr_q, maddr_d;
   logic              mrd_q, mrd_d;
   logic              mwr_q, mwr_d;
   logic [7:0]        mdin_q, mdin_d;
   logic              busy_q, busy_d;
   logic              found, last;
   logic [DW-1:0]     cand, pick;

`ifdef SD_WRPROT_EN
   logic wp_hit_q, wp_hit_d, wp_err_q, wp_err_d;
   assign wp_err = wp_err_q;
`else
   logic wp_hit_q;
   assign wp_hit_q = 1'b0;
`endif

   // Each drive owns a quarter of the image space; lba/offset overflow wraps silently.
   function automatic logic [MEM_AW-1:0] addr_of(input logic [DW-1:0] d, input logic [31:0] lba,
                                                 input logic [12:0] off);
      return (MEM_AW'(d) << (MEM_AW - 2)) + MEM_AW'({lba, 9'd0}) + MEM_AW'(off);
   endfunction

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      drv_d    = drv_q;
      dir_rd_d = dir_rd_q;
      lba_d    = lba_q;
      cnt_d    = cnt_q;
      off_d    = off_q;
      ack_d    = ack_q;
      baddr_d  = baddr_q;
      bdout_d  = bdout_q;
      bwr_d    = 1'b0;
      maddr_d  = maddr_q;
      mrd_d    = mrd_q;
      mwr_d    = mwr_q;
      mdin_d   = mdin_q;
      busy_d   = busy_q;
`ifdef SD_WRPROT_EN
      wp_hit_d = wp_hit_q;
      wp_err_d = wp_err_q;
`endif
      found = 1'b0;
      cand  = '0;
      pick  = '0;
      for (int i = 0; i < NDR; i++) begin
         pick = DW'((int'(rr_q) + i) % NDR);
         if (!found && (bus.sd_rd[pick] || bus.sd_wr[pick])) begin
            found = 1'b1;
            cand  = pick;
         end
      end
      last = (off_q == {cnt_q, 9'h1FF});

      case (state_q)
         IDLE: if (found) begin
            state_d  = GRANT;
            drv_d    = cand;
            dir_rd_d = bus.sd_rd[cand];
            lba_d    = bus.sd_lba[cand];
            cnt_d    = (bus.sd_blk_cnt[cand] > 6'd15) ? 4'hF : bus.sd_blk_cnt[cand][3:0];
            off_d    = '0;
`ifdef SD_WRPROT_EN
            wp_hit_d = wp[cand];
`endif
         end
         GRANT: begin
            ack_d        = '0;
            ack_d[drv_q] = 1'b1;
            busy_d       = 1'b1;
            if (dir_rd_q) begin
               state_d = RD_REQ;
               mrd_d   = 1'b1;
               maddr_d = addr_of(drv_q, lba_q, off_q);
            end else begin
               state_d = WR_ADDR;
               baddr_d = off_q;
            end
         end
         RD_REQ: if (bus.mem_ready) begin
            state_d = RD_PUT;
            mrd_d   = 1'b0;
            bdout_d = bus.mem_dout;
            baddr_d = off_q;
            bwr_d   = 1'b1;
         end
         RD_PUT: begin
            off_d = off_q + 13'd1;
            if (last) begin
               state_d = DONE;
               ack_d   = '0;
               busy_d  = 1'b0;
            end else begin
               state_d = RD_REQ;
               mrd_d   = 1'b1;
               maddr_d = addr_of(drv_q, lba_q, off_q + 13'd1);
            end
         end
         WR_ADDR: state_d = WR_CAP;
         WR_CAP, WR_MEM: begin
            if (state_q == WR_CAP) mdin_d = bus.sd_buff_din[drv_q];
            if (state_q == WR_CAP && !wp_hit_q) begin
               state_d = WR_MEM;
               mwr_d   = 1'b1;
               maddr_d = addr_of(drv_q, lba_q, off_q);
            end else if (state_q == WR_CAP || bus.mem_ready) begin
               // Protected writes fall through here straight from WR_CAP without touching memory.
               mwr_d = 1'b0;
               off_d = off_q + 13'd1;
               if (last) begin
                  state_d = DONE;
                  ack_d   = '0;
                  busy_d  = 1'b0;
               end else begin
                  state_d = WR_ADDR;
                  baddr_d = off_q + 13'd1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            rr_d    = (drv_q == DW'(NDR - 1)) ? '0 : drv_q + 1'b1;
`ifdef SD_WRPROT_EN
            wp_err_d = wp_err_q | (wp_hit_q & ~dir_rd_q);
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         rr_q     <= '0;
         drv_q    <= '0;
         dir_rd_q <= 1'b0;
         lba_q    <= '0;
         cnt_q    <= '0;
         off_q    <= '0;
         ack_q    <= '0;
         baddr_q  <= '0;
         bdout_q  <= '0;
         bwr_q    <= 1'b0;
         maddr_q  <= '0;
         mrd_q    <= 1'b0;
         mwr_q    <= 1'b0;
         mdin_q   <= '0;
         busy_q   <= 1'b0;
`ifdef SD_WRPROT_EN
         wp_hit_q <= 1'b0;
         wp_err_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         drv_q    <= drv_d;
         dir_rd_q <= dir_rd_d;
         lba_q    <= lba_d;
         cnt_q    <= cnt_d;
         off_q    <= off_d;
         ack_q    <= ack_d;
         baddr_q  <= baddr_d;
         bdout_q  <= bdout_d;
         bwr_q    <= bwr_d;
         maddr_q  <= maddr_d;
         mrd_q    <= mrd_d;
         mwr_q    <= mwr_d;
         mdin_q   <= mdin_d;
         busy_q   <= busy_d;
`ifdef SD_WRPROT_EN
         wp_hit_q <= wp_hit_d;
         wp_err_q <= wp_err_d;
`endif
      end
   end

   assign bus.sd_ack       = ack_q;
   assign bus.sd_buff_addr = baddr_q;
   assign bus.sd_buff_dout = bdout_q;
   assign bus.sd_buff_wr   = bwr_q;
   assign bus.mem_addr     = maddr_q;
   assign bus.mem_rd       = mrd_q;
   assign bus.mem_wr       = mwr_q;
   assign bus.mem_din      = mdin_q;
   assign bus.busy         = busy_q;
endmodule

// File: tb/tb_iec_sd_responder.sv
// Scoreboard bench for iec_sd_responder: expected buffer bytes / memory writes are queued at
// request time from a byte-level image model and popped by monitors as the DUT produces them.
module tb_iec_sd_responder;
   localparam int NDR    = 2;
   localparam int MEM_AW = 24;
   localparam int AMASK  = (1 << MEM_AW) - 1;

   logic clk_sys = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk_sys = ~clk_sys;

   iec_sd_responder_if #(.NDR(NDR), .MEM_AW(MEM_AW)) bus ();
`ifdef SD_WRPROT_EN
   logic [NDR-1:0] wp = '0;
   logic           wp_err;
`endif

   iec_sd_responder #(.DRIVES(NDR), .MEM_AW(MEM_AW)) dut (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .bus     (bus)
`ifdef SD_WRPROT_EN
     ,.wp      (wp),
      .wp_err  (wp_err)
`endif
   );

   typedef struct { int drv; int off; int addr; logic [7:0] data; } rd_exp_t;
   typedef struct { int addr; logic [7:0] data; } wr_exp_t;
   rd_exp_t rdq[$];
   wr_exp_t wrq[$];

   logic [7:0] mem [int];
   logic [7:0] dbuf [NDR][8192];
   int vectors = 0, miscompares = 0;
   int lat_fixed = 0;
   int rr_m = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] mem_rd_f(input int a);
      if (mem.exists(a)) return mem[a];
      return 8'(a) ^ 8'h5A;
   endfunction

   function automatic int maddr(input int d, input logic [31:0] lba, input int k);
      longint a;
      a = (longint'(d) << (MEM_AW - 2)) + (longint'(lba) << 9) + longint'(k);
      return int'(a & longint'(AMASK));
   endfunction

   function automatic int rr_pick(input logic [NDR-1:0] pend);
      for (int i = 0; i < NDR; i++)
         if (pend[(rr_m + i) % NDR]) return (rr_m + i) % NDR;
      return -1;
   endfunction

   // Image memory: strobe seen -> ready after lat_fixed (or random 0..2) extra cycles.
   // It also acts as the write monitor, since it sees each completing mem_wr.
   int  wcnt = 0;
   bit  acc  = 1'b0;
   always @(negedge clk_sys) begin
      if (!reset_n) begin
         bus.mem_ready = 1'b0;
         bus.mem_dout  = 8'h00;
         acc = 1'b0;
      end else if (bus.mem_ready) begin
         bus.mem_ready = 1'b0;
         acc = 1'b0;
      end else if (bus.mem_rd || bus.mem_wr) begin
         if (!acc) begin
            acc  = 1'b1;
            wcnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 2));
         end
         if (wcnt == 0) begin
            bus.mem_ready = 1'b1;
            if (bus.mem_rd) bus.mem_dout = mem_rd_f(int'(bus.mem_addr));
            if (bus.mem_wr) begin
               if (wrq.size() == 0) check("wr_unexpected", 1, 0);
               else begin
                  wr_exp_t w;
                  w = wrq.pop_front();
                  check("wr_addr", bus.mem_addr, w.addr);
                  check("wr_data", bus.mem_din, w.data);
               end
               mem[int'(bus.mem_addr)] = bus.mem_din;
            end
         end else wcnt--;
      end else acc = 1'b0;
   end

   // Drive sector buffers: data follows the address the DUT presents.
   always @(negedge clk_sys)
      for (int d = 0; d < NDR; d++) bus.sd_buff_din[d] = dbuf[d][bus.sd_buff_addr];

   // Read monitor: every sd_buff_wr pulse must match the next expected byte.
   always @(negedge clk_sys) begin
      if (reset_n && bus.sd_buff_wr) begin
         if (rdq.size() == 0) check("rd_unexpected", 1, 0);
         else begin
            rd_exp_t e;
            e = rdq.pop_front();
            check("rd_ack", bus.sd_ack, 64'(1) << e.drv);
            check("rd_off", bus.sd_buff_addr, e.off);
            check("rd_maddr", bus.mem_addr, e.addr);
            check("rd_data", bus.sd_buff_dout, e.data);
         end
      end
   end

   task automatic setup(input int d, input bit rd, input logic [31:0] lba, input int blk,
                        input bit pat);
      int len;
      bus.sd_lba[d]     = lba;
      bus.sd_blk_cnt[d] = 6'(blk);
      len = ((blk > 15) ? 16 : blk + 1) * 512;
      for (int k = 0; k < len; k++) begin
         int a;
         a = maddr(d, lba, k);
         if (rd) rdq.push_back('{d, k, a, mem_rd_f(a)});
         else begin
            dbuf[d][k] = pat ? 8'(k) : 8'($urandom);
            wrq.push_back('{a, dbuf[d][k]});
         end
      end
   endtask

   task automatic wait_ack(input int d, input bit chk_lat);
      int n = 0;
      while (bus.sd_ack == '0 && n < 50) begin
         @(negedge clk_sys);
         n++;
      end
      if (chk_lat) check("ack_latency", n, 2);
      check("ack_drive", bus.sd_ack, 64'(1) << d);
      check("busy_on", bus.busy, 1);
   endtask

   task automatic wait_idle(input int d, input bit chk_q);
      int n = 0;
      while (bus.busy && n < 40000) begin
         @(negedge clk_sys);
         n++;
      end
      check("busy_off", bus.busy, 0);
      check("ack_off", bus.sd_ack, 0);
      rr_m = (d + 1) % NDR;
      @(negedge clk_sys);
      if (chk_q) begin
         check("rd_left", rdq.size(), 0);
         check("wr_left", wrq.size(), 0);
      end
   endtask

   task automatic run_one(input int d, input bit rd, input logic [31:0] lba, input int blk,
                          input bit pat);
      setup(d, rd, lba, blk, pat);
      if (rd) bus.sd_rd[d] = 1'b1;
      else    bus.sd_wr[d] = 1'b1;
      wait_ack(d, 1'b1);
      bus.sd_rd[d] = 1'b0;
      bus.sd_wr[d] = 1'b0;
      wait_idle(d, 1'b1);
   endtask

   task automatic arb_pair();
      int first, second;
      first  = rr_pick(2'b11);
      second = 1 - first;
      setup(first, 1'b1, 32'($urandom_range(0, 255)), 0, 1'b0);
      setup(second, 1'b1, 32'($urandom_range(0, 255)), 0, 1'b0);
      bus.sd_rd = 2'b11;
      wait_ack(first, 1'b1);
      bus.sd_rd[first] = 1'b0;
      wait_idle(first, 1'b0);
      wait_ack(second, 1'b0);
      bus.sd_rd[second] = 1'b0;
      wait_idle(second, 1'b1);
   endtask

   initial begin
      int n;
      bus.sd_rd      = '0;
      bus.sd_wr      = '0;
      bus.sd_lba     = '0;
      bus.sd_blk_cnt = '0;
      for (int d = 0; d < NDR; d++)
         for (int k = 0; k < 8192; k++) dbuf[d][k] = 8'h00;
      repeat (3) @(negedge clk_sys);
      check("rst_ack", bus.sd_ack, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_mem_rd", bus.mem_rd, 0);
      check("rst_mem_wr", bus.mem_wr, 0);
      check("rst_buff_wr", bus.sd_buff_wr, 0);
      check("rst_buff_addr", bus.sd_buff_addr, 0);
      reset_n = 1'b1;
      @(negedge clk_sys);

      // zero-wait read, then 2-block write with slow memory
      lat_fixed = 0;
      run_one(0, 1'b1, 32'd3, 0, 1'b0);
      lat_fixed = 3;
      run_one(1, 1'b0, 32'd0, 1, 1'b1);
      check("wr_buff_addr_end", bus.sd_buff_addr, 1023);
      check("wr_image", mem_rd_f((1 << 22) + 700), 700 & 255);

      // simultaneous requests alternate between drives
      lat_fixed = 1;
      repeat (2) arb_pair();

      // read and write from one drive at once: read first, write on the next grant
      lat_fixed = 0;
      setup(0, 1'b1, 32'd7, 0, 1'b0);
      setup(0, 1'b0, 32'd7, 0, 1'b0);
      bus.sd_rd[0] = 1'b1;
      bus.sd_wr[0] = 1'b1;
      wait_ack(0, 1'b1);
      bus.sd_rd[0] = 1'b0;
      wait_idle(0, 1'b0);
      wait_ack(0, 1'b0);
      bus.sd_wr[0] = 1'b0;
      wait_idle(0, 1'b1);

      // reset in the middle of a read
      setup(0, 1'b1, 32'd9, 0, 1'b0);
      bus.sd_rd[0] = 1'b1;
      wait_ack(0, 1'b1);
      bus.sd_rd[0] = 1'b0;
      n = 0;
      while (!(bus.sd_buff_wr && bus.sd_buff_addr == 13'd100) && n < 2000) begin
         @(negedge clk_sys);
         n++;
      end
      check("mid_off_100", bus.sd_buff_addr, 100);
      reset_n = 1'b0;
      @(negedge clk_sys);
      check("mid_rst_ack", bus.sd_ack, 0);
      check("mid_rst_mem_rd", bus.mem_rd, 0);
      check("mid_rst_busy", bus.busy, 0);
      rdq.delete();
      rr_m = 0;
      reset_n = 1'b1;
      @(negedge clk_sys);
      run_one(1, 1'b1, 32'd9, 0, 1'b0);

      // block count above 15 clamps to 16 blocks
      run_one(0, 1'b1, 32'h10, 20, 1'b0);
      check("clamp_buff_addr_end", bus.sd_buff_addr, 8191);

      // random traffic, random memory latency, full-range lba (exercises address wrap)
      lat_fixed = -1;
      repeat (8)
         run_one(int'($urandom_range(0, NDR - 1)), 1'($urandom_range(0, 1)), $urandom,
                 int'($urandom_range(0, 1)), 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end
endmodule
